mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single behavioural memory port (`mem_intf`, registered read, one-cycle latency) between the core's instruction-fetch path and its load/store path. It accepts at most one request per cycle using round-robin priority, drives the memory's read and write channels, and routes each response back to its owner. The arbiter sits between the core's fetch/LSU logic and the `mem` instance.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 40 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
package mem_arbiter_pkg;

  // Identity of a requester; doubles as the round-robin "last granted" pointer.
  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_D  = 1'b1
  } arb_port_e;

  // One-entry record of the request accepted last cycle, used to steer the response.
  typedef struct packed {
    logic      valid;
    arb_port_e owner;
    logic      we;
    logic      err;
  } arb_inflight_t;

  // Pointer value after reset: D counts as last granted, so IF wins first contention.
  localparam arb_port_e ARB_RESET_LAST = ARB_D;

  // Only word-aligned accesses are serviced.
  function automatic logic arb_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with a registered last-grant pointer.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic i_rst,
  input  logic i_req_if,
  input  logic i_req_d,
  input  logic i_advance,
  output logic o_gnt_if,
  output logic o_gnt_d
);

  arb_port_e r_last;
  arb_port_e w_last_nxt;

  // Pointer register: remembers which port was granted most recently.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_last <= ARB_RESET_LAST;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // Pointer moves only when the granted request was actually taken.
  always_comb begin
    w_last_nxt = r_last;
    if (i_advance) begin
      w_last_nxt = o_gnt_d ? ARB_D : ARB_IF;
    end
  end

  // Grant: a lone requester wins; under contention the port not granted last wins.
  always_comb begin
    o_gnt_if = i_req_if && (!i_req_d || (r_last == ARB_D));
    o_gnt_d  = i_req_d  && (!i_req_if || (r_last == ARB_IF));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory port between instruction fetch and load/store.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRWIDTH = 32,
  parameter int BUSWIDTH  = 32,
  parameter int WORDIDX   = 10
) (
  input  logic                 clk,
  input  logic                 cpu_rst,
  // fetch port
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [ADDRWIDTH-1:0] if_req_addr,
  output logic                 if_resp_valid,
  output logic [BUSWIDTH-1:0]  if_resp_rdata,
  output logic                 if_resp_err,
  // load/store port
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_we,
  input  logic [ADDRWIDTH-1:0] d_req_addr,
  input  logic [BUSWIDTH-1:0]  d_req_wdata,
  output logic                 d_resp_valid,
  output logic [BUSWIDTH-1:0]  d_resp_rdata,
  output logic                 d_resp_err,
  // memory side
  output logic [ADDRWIDTH-1:0] mem_rd_addr,
  output logic [ADDRWIDTH-1:0] mem_wr_addr,
  output logic [BUSWIDTH-1:0]  mem_wr_data,
  output logic                 mem_wren,
  input  logic [BUSWIDTH-1:0]  mem_rd_data
);

  logic                 w_gnt_if;
  logic                 w_gnt_d;
  logic                 w_acc_if;
  logic                 w_acc_d;
  logic                 w_accept;
  logic [ADDRWIDTH-1:0] w_sel_addr;
  logic                 w_sel_we;
  logic                 w_sel_err;
  logic [ADDRWIDTH-1:0] w_word_idx;
  logic                 w_rd_go;
  logic                 w_wr_go;
  logic                 w_unused_addr_hi;
  arb_inflight_t        w_inflight_nxt;
  arb_inflight_t        r_inflight;
  logic [ADDRWIDTH-1:0] r_rd_addr;
  logic [ADDRWIDTH-1:0] r_wr_addr;
  logic [BUSWIDTH-1:0]  r_wr_data;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .i_rst     (cpu_rst),
    .i_req_if  (if_req_valid),
    .i_req_d   (d_req_valid),
    .i_advance (w_accept),
    .o_gnt_if  (w_gnt_if),
    .o_gnt_d   (w_gnt_d)
  );

  // Accept and select the single granted request; nothing is accepted while in reset.
  always_comb begin
    w_acc_if     = w_gnt_if && !cpu_rst;
    w_acc_d      = w_gnt_d  && !cpu_rst;
    w_accept     = w_acc_if || w_acc_d;
    if_req_ready = w_acc_if;
    d_req_ready  = w_acc_d;
    w_sel_addr   = w_acc_d ? d_req_addr : if_req_addr;
    w_sel_we     = w_acc_d && d_req_we;
    w_sel_err    = arb_misaligned(w_sel_addr[1:0]);
    w_word_idx   = '0;
    w_word_idx[WORDIDX-1:0] = w_sel_addr[WORDIDX+1:2];
    w_rd_go      = w_accept && !w_sel_we && !w_sel_err;
    w_wr_go      = w_accept &&  w_sel_we && !w_sel_err;
    w_unused_addr_hi = ^w_sel_addr[ADDRWIDTH-1:WORDIDX+2];
  end

  // Memory channels: new address on a valid access, otherwise hold the last one.
  always_comb begin
    mem_rd_addr = w_rd_go ? w_word_idx  : r_rd_addr;
    mem_wr_addr = w_wr_go ? w_word_idx  : r_wr_addr;
    mem_wr_data = w_wr_go ? d_req_wdata : r_wr_data;
    mem_wren    = w_wr_go;
  end

  // Next in-flight record describing this cycle's accepted request.
  always_comb begin
    w_inflight_nxt       = '0;
    w_inflight_nxt.valid = w_accept;
    w_inflight_nxt.owner = w_acc_d ? ARB_D : ARB_IF;
    w_inflight_nxt.we    = w_sel_we;
    w_inflight_nxt.err   = w_sel_err;
  end

  // Response register plus held memory-channel values.
  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_inflight <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_rd_addr  <= mem_rd_addr;
      r_wr_addr  <= mem_wr_addr;
      r_wr_data  <= mem_wr_data;
    end
  end

  // Route the response to its owner; data only for successful reads, silenced in reset.
  always_comb begin
    if_resp_valid = r_inflight.valid && (r_inflight.owner == ARB_IF) && !cpu_rst;
    d_resp_valid  = r_inflight.valid && (r_inflight.owner == ARB_D)  && !cpu_rst;
    if_resp_err   = if_resp_valid && r_inflight.err;
    d_resp_err    = d_resp_valid  && r_inflight.err;
    if_resp_rdata = (if_resp_valid && !r_inflight.err) ? mem_rd_data : '0;
    d_resp_rdata  = (d_resp_valid && !r_inflight.err && !r_inflight.we) ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter with a behavioural registered-read memory.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 32;
  localparam int WI = 10;

  logic          clk = 1'b0;
  logic          cpu_rst;
  logic          if_req_valid, if_req_ready;
  logic [AW-1:0] if_req_addr;
  logic          if_resp_valid, if_resp_err;
  logic [BW-1:0] if_resp_rdata;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [BW-1:0] d_req_wdata;
  logic          d_resp_valid, d_resp_err;
  logic [BW-1:0] d_resp_rdata;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [BW-1:0] mem_wr_data, mem_rd_data;
  logic          mem_wren;

  // backdoor preload port of the memory model
  logic          pl_en;
  logic [WI-1:0] pl_idx;
  logic [BW-1:0] pl_data;
  logic [BW-1:0] ram [0:(1<<WI)-1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDRWIDTH(AW), .BUSWIDTH(BW), .WORDIDX(WI)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wren(mem_wren), .mem_rd_data(mem_rd_data)
  );

  // Memory: write on wren, registered read with one-cycle latency.
  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (mem_wren) ram[mem_wr_addr[WI-1:0]] <= mem_wr_data;
    mem_rd_data <= ram[mem_rd_addr[WI-1:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd);
    if_req_valid = iv;  if_req_addr = ia;
    d_req_valid  = dv;  d_req_we = dwe;  d_req_addr = da;  d_req_wdata = dwd;
  endtask

  typedef struct {
    logic        if_v;  logic [31:0] if_a;
    logic        d_v;   logic d_we;  logic [31:0] d_a;  logic [31:0] d_wd;
    logic        e_if_rdy;  logic e_d_rdy;  logic e_wren;
    logic        e_if_rv;   logic e_if_err;  logic [31:0] e_if_rd;
    logic        e_d_rv;    logic e_d_err;   logic [31:0] e_d_rd;
    logic [31:0] e_rd_addr;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // inputs: if_v if_a d_v d_we d_a d_wd | expected: if_rdy d_rdy wren if_rv if_err if_rd d_rv d_err d_rd rd_addr
    // (responses in a row belong to the request accepted in the previous row)
    vecs[0]  = '{1, 32'h0,  1, 0, 32'h8,  32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'd0};
    vecs[1]  = '{1, 32'h0,  1, 0, 32'h8,  32'h0,        0, 1, 0, 1, 0, 32'h11110000, 0, 0, 32'h0,        32'd2};
    vecs[2]  = '{1, 32'h0,  1, 0, 32'h8,  32'h0,        1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h22220008, 32'd0};
    vecs[3]  = '{1, 32'h0,  1, 0, 32'h8,  32'h0,        0, 1, 0, 1, 0, 32'h11110000, 0, 0, 32'h0,        32'd2};
    vecs[4]  = '{1, 32'h10, 0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h22220008, 32'd4};
    vecs[5]  = '{0, 32'h0,  1, 1, 32'h20, 32'h12345678, 0, 1, 1, 1, 0, 32'hDEADBEEF, 0, 0, 32'h0,        32'd4};
    vecs[6]  = '{0, 32'h0,  1, 0, 32'h20, 32'h0,        0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'd8};
    vecs[7]  = '{1, 32'h6,  0, 0, 32'h0,  32'h0,        1, 0, 0, 0, 0, 32'h0,        1, 0, 32'h12345678, 32'd8};
    vecs[8]  = '{1, 32'h0,  0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 1, 32'h0,        0, 0, 32'h0,        32'd0};
    vecs[9]  = '{1, 32'h4,  0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 0, 32'h11110000, 0, 0, 32'h0,        32'd1};
    vecs[10] = '{1, 32'h8,  0, 0, 32'h0,  32'h0,        1, 0, 0, 1, 0, 32'h11110004, 0, 0, 32'h0,        32'd2};
    vecs[11] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h22220008, 0, 0, 32'h0,        32'd2};
    vecs[12] = '{0, 32'h0,  1, 1, 32'h22, 32'hFFFF0000, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'd2};
    vecs[13] = '{0, 32'h0,  1, 0, 32'h20, 32'h0,        0, 1, 0, 0, 0, 32'h0,        1, 1, 32'h0,        32'd8};
    vecs[14] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h12345678, 32'd8};
    vecs[15] = '{0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'd8};

    cpu_rst = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    drive(1, 32'h0, 1, 0, 32'h8, 32'h0);

    // preload memory while the arbiter is held in reset
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      pl_en = 1'b1;
      case (k)
        0: begin pl_idx = 10'd0; pl_data = 32'h11110000; end
        1: begin pl_idx = 10'd1; pl_data = 32'h11110004; end
        2: begin pl_idx = 10'd2; pl_data = 32'h22220008; end
        3: begin pl_idx = 10'd4; pl_data = 32'hDEADBEEF; end
        default: begin pl_idx = 10'd8; pl_data = 32'h55550020; end
      endcase
    end
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    // reset state with both requesters pushing
    chk("rst if_rdy", {31'd0, if_req_ready}, 32'd0);
    chk("rst d_rdy",  {31'd0, d_req_ready},  32'd0);
    chk("rst resp_v", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
    chk("rst err",    {30'd0, if_resp_err, d_resp_err},     32'd0);
    chk("rst wren",   {31'd0, mem_wren}, 32'd0);
    chk("rst rd_addr", mem_rd_addr, 32'd0);
    chk("rst wr_addr", mem_wr_addr, 32'd0);
    chk("rst wr_data", mem_wr_data, 32'd0);
    chk("rst rdata",  if_resp_rdata | d_resp_rdata, 32'd0);

    @(negedge clk);
    cpu_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].if_v, vecs[i].if_a, vecs[i].d_v, vecs[i].d_we, vecs[i].d_a, vecs[i].d_wd);
      #1;
      chk($sformatf("r%0d if_rdy", i),  {31'd0, if_req_ready},  {31'd0, vecs[i].e_if_rdy});
      chk($sformatf("r%0d d_rdy", i),   {31'd0, d_req_ready},   {31'd0, vecs[i].e_d_rdy});
      chk($sformatf("r%0d wren", i),    {31'd0, mem_wren},      {31'd0, vecs[i].e_wren});
      chk($sformatf("r%0d if_rv", i),   {31'd0, if_resp_valid}, {31'd0, vecs[i].e_if_rv});
      chk($sformatf("r%0d if_err", i),  {31'd0, if_resp_err},   {31'd0, vecs[i].e_if_err});
      chk($sformatf("r%0d if_rdata", i), if_resp_rdata, vecs[i].e_if_rd);
      chk($sformatf("r%0d d_rv", i),    {31'd0, d_resp_valid},  {31'd0, vecs[i].e_d_rv});
      chk($sformatf("r%0d d_err", i),   {31'd0, d_resp_err},    {31'd0, vecs[i].e_d_err});
      chk($sformatf("r%0d d_rdata", i), d_resp_rdata, vecs[i].e_d_rd);
      chk($sformatf("r%0d rd_addr", i), mem_rd_addr, vecs[i].e_rd_addr);
    end

    // reset the cycle after a load accept: the pending response must vanish
    @(negedge clk);
    drive(0, 0, 1, 0, 32'h20, 0);
    #1;
    chk("rl load accept", {31'd0, d_req_ready}, 32'd1);
    @(negedge clk);
    cpu_rst = 1'b1;
    drive(1, 32'h4, 1, 0, 32'h8, 0);
    #1;
    chk("rl d_rv in rst", {31'd0, d_resp_valid}, 32'd0);
    chk("rl rdy in rst",  {30'd0, if_req_ready, d_req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    cpu_rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rl resp_v after", {30'd0, if_resp_valid, d_resp_valid}, 32'd0);
    chk("rl rdata after",  if_resp_rdata | d_resp_rdata, 32'd0);
    chk("rl err after",    {30'd0, if_resp_err, d_resp_err}, 32'd0);
    chk("rl rd_addr after", mem_rd_addr, 32'd0);
    chk("rl wr_addr after", mem_wr_addr, 32'd0);
    chk("rl wr_data after", mem_wr_data, 32'd0);
    chk("rl wren after",   {31'd0, mem_wren}, 32'd0);
    @(negedge clk);
    drive(1, 32'h4, 1, 0, 32'h8, 0);
    #1;
    chk("rl first grant", {30'd0, if_req_ready, d_req_ready}, 32'd2);
    @(negedge clk);
    #1;
    chk("rl second grant", {30'd0, if_req_ready, d_req_ready}, 32'd1);
    chk("rl if resp", if_resp_rdata, 32'h11110004);
    chk("rl if rv",   {31'd0, if_resp_valid}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rl d resp", d_resp_rdata, 32'h22220008);
    chk("rl d rv",   {31'd0, d_resp_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
